// File: rtl/stack_sequencer.sv
// stack_sequencer: expands push/pop masks into SS:SP word bus transactions (abort port with STACK_SEQ_ABORT_EN)
module stack_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  input  logic [15:0] ss_in,
  output logic [3:0]  value_sel,
  input  logic [15:0] value_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        wr_en,
  output logic [3:0]  wr_sel,
  output logic [15:0] wr_data,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic        busy,
`ifdef STACK_SEQ_ABORT_EN
  output logic        done,
  input  logic        abort
`else
  output logic        done
`endif
);
  typedef enum logic [1:0] {IDLE, POP, PUSH, FINISH} state_t;
  state_t state, state_nx;
  logic [15:0] pop_m, push_m, pop_nx, push_nx, sp_cur, sp_nx, ss, sp_start;
  logic [15:0] pop_left, push_left, bus_sp;
  logic [3:0] pop_idx, push_idx;
  logic kill, req;
`ifdef STACK_SEQ_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  // pops take the highest pending item, pushes the lowest
  always_comb begin
    pop_idx = '0;
    push_idx = '0;
    for (int i = 0; i < 16; i++) if (pop_m[i]) pop_idx = 4'(i);
    for (int i = 15; i >= 0; i--) if (push_m[i]) push_idx = 4'(i);
  end
  assign pop_left = pop_m & ~(16'h1 << pop_idx);
  assign push_left = push_m & ~(16'h1 << push_idx);
  assign req = state == POP || state == PUSH;
  assign bus_sp = state == PUSH ? sp_cur - 16'd2 : sp_cur;
  assign mem_req = req;
  assign mem_we = state == PUSH;
  assign mem_addr = req ? {ss, 4'h0} + {4'h0, bus_sp} : '0;
  assign value_sel = state == PUSH ? push_idx : '0;
  assign mem_wdata = state == PUSH ? (push_idx == 4'd4 ? sp_start : value_in) : '0;
  assign done = state == FINISH;
  assign sp_we = done;
  assign sp_out = done ? sp_cur : '0;
  assign busy = state != IDLE;
  // next state, working masks and SP; pops drain before pushes
  always_comb begin
    state_nx = state;
    pop_nx = pop_m;
    push_nx = push_m;
    sp_nx = sp_cur;
    case (state)
      IDLE: if (start) begin
        pop_nx = pop_mask;
        push_nx = push_mask;
        sp_nx = sp_in;
        state_nx = |pop_mask ? POP : |push_mask ? PUSH : FINISH;
      end
      POP: if (mem_ack) begin
        pop_nx = pop_left;
        sp_nx = sp_cur + 16'd2;
        state_nx = |pop_left ? POP : |push_m ? PUSH : FINISH;
      end
      PUSH: if (mem_ack) begin
        push_nx = push_left;
        sp_nx = sp_cur - 16'd2;
        state_nx = |push_left ? PUSH : FINISH;
      end
      default: state_nx = IDLE;
    endcase
    if (kill) begin
      state_nx = IDLE;
      pop_nx = '0;
      push_nx = '0;
      sp_nx = sp_cur;
    end
  end
  // state, working registers and the registered pop writeback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pop_m <= '0;
      push_m <= '0;
      sp_cur <= '0;
      ss <= '0;
      sp_start <= '0;
      wr_en <= 1'b0;
      wr_sel <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nx;
      pop_m <= pop_nx;
      push_m <= push_nx;
      sp_cur <= sp_nx;
      wr_en <= state == POP && mem_ack && !kill && pop_idx != 4'd4;
      if (state == IDLE && start) begin
        ss <= ss_in;
        sp_start <= sp_in;
      end
      if (state == POP && mem_ack) begin
        wr_sel <= pop_idx;
        wr_data <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: scoreboard bench for stack_sequencer
module tb_stack_sequencer;
  logic clk = 0, reset_n = 0, start = 0, mem_ack = 0, abort = 0;
  logic [15:0] push_mask = 0, pop_mask = 0, sp_in = 0, ss_in = 0, value_in, mem_rdata = 0;
  logic [3:0] value_sel, wr_sel;
  logic mem_req, mem_we, wr_en, sp_we, busy, done;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, wr_data, sp_out;
  int tests = 0, fails = 0;
  typedef struct {logic we; logic [19:0] addr; logic [15:0] wdata; logic [15:0] rdata;} bus_t;
  typedef struct {logic [3:0] sel; logic [15:0] data;} wb_t;
  bus_t exp_bus[$];
  wb_t exp_wb[$];
  logic [15:0] rd_q[$];

  stack_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .push_mask(push_mask), .pop_mask(pop_mask),
    .sp_in(sp_in), .ss_in(ss_in), .value_sel(value_sel), .value_in(value_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .sp_out(sp_out), .sp_we(sp_we), .busy(busy),
`ifdef STACK_SEQ_ABORT_EN
    .done(done), .abort(abort)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] vfun(input logic [3:0] s);
    return {4'hA, s, 4'h5, ~s};
  endfunction
  function automatic logic [19:0] addr_of(input logic [15:0] ss, input logic [15:0] sp);
    return {ss, 4'h0} + {4'h0, sp};
  endfunction
  assign value_in = vfun(value_sel);

  task automatic run_seq(input logic [15:0] pm, input logic [15:0] pp, input logic [15:0] sp,
                         input logic [15:0] ss, input int wt, input bit dup_start,
                         output int dcyc, output int nreq);
    logic [15:0] s, rd;
    int n, w;
    bus_t b;
    wb_t wb;
    s = sp; n = 0; w = 0;
    exp_bus.delete();
    exp_wb.delete();
    for (int i = 15; i >= 0; i--) if (pp[i]) begin
      rd = rd_q.size() != 0 ? rd_q.pop_front() : 16'h3C00 + 16'(n);
      b = '{1'b0, addr_of(ss, s), 16'h0, rd};
      exp_bus.push_back(b);
      if (i != 4) begin
        wb = '{4'(i), rd};
        exp_wb.push_back(wb);
      end
      s += 16'd2;
      n++;
    end
    for (int i = 0; i < 16; i++) if (pm[i]) begin
      s -= 16'd2;
      b = '{1'b1, addr_of(ss, s), (i == 4) ? sp : vfun(4'(i)), 16'h0};
      exp_bus.push_back(b);
      n++;
    end
    @(negedge clk);
    start = 1; push_mask = pm; pop_mask = pp; sp_in = sp; ss_in = ss;
    dcyc = -1; nreq = 0;
    for (int c = 1; c <= 300 && dcyc < 0; c++) begin
      @(negedge clk);
      start = dup_start && c == 2;
      push_mask = start ? 16'hFFFF : 16'h0;
      pop_mask = start ? 16'h00FF : 16'h0;
      sp_in = start ? 16'h5555 : 16'h0;
      mem_ack = 0;
      if (wr_en) begin
        tests++;
        if (exp_wb.size() == 0) begin
          fails++;
          $display("FAIL wb_extra: got wr_en sel=%0d data=%h, required none", wr_sel, wr_data);
        end else begin
          wb = exp_wb.pop_front();
          if (wr_sel !== wb.sel || wr_data !== wb.data) begin
            fails++;
            $display("FAIL wb: got sel=%0d data=%h, required sel=%0d data=%h", wr_sel, wr_data, wb.sel, wb.data);
          end
        end
      end
      if (mem_req) begin
        nreq++;
        tests++;
        if (exp_bus.size() == 0) begin
          fails++;
          $display("FAIL bus_extra: got we=%b addr=%h, required no request", mem_we, mem_addr);
        end else begin
          b = exp_bus[0];
          if (mem_we !== b.we || mem_addr !== b.addr || (b.we && mem_wdata !== b.wdata)) begin
            fails++;
            $display("FAIL bus: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, b.we, b.addr, b.wdata);
          end
          if (w == wt) begin
            mem_ack = 1; mem_rdata = b.rdata; exp_bus.delete(0); w = 0;
          end else begin
            w++; mem_rdata = 16'hDEAD;
          end
        end
      end
      if (done) begin
        dcyc = c;
        tests++;
        if (sp_we !== 1 || sp_out !== s || mem_req !== 0 || exp_bus.size() != 0 || exp_wb.size() != 0) begin
          fails++;
          $display("FAIL finish: got sp_we=%b sp_out=%h req=%b left=%0d/%0d, required sp_we=1 sp_out=%h req=0 left=0/0",
                   sp_we, sp_out, mem_req, exp_bus.size(), exp_wb.size(), s);
        end
      end
    end
    start = 0; mem_ack = 0; push_mask = 0; pop_mask = 0;
    if (dcyc < 0) begin
      tests++; fails++;
      $display("FAIL timeout: done not seen within 300 cycles");
    end
    tests++;
    if (dcyc != n * (wt + 1) + 1) begin
      fails++;
      $display("FAIL latency: got done at cycle %0d, required %0d", dcyc, n * (wt + 1) + 1);
    end
    @(negedge clk);
    tests++;
    if (busy !== 0 || done !== 0 || sp_we !== 0 || mem_req !== 0) begin
      fails++;
      $display("FAIL idle_after: got busy=%b done=%b sp_we=%b req=%b, required all 0", busy, done, sp_we, mem_req);
    end
  endtask

  task automatic test_reset;
    reset_n = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, wr_en, wr_sel, wr_data, sp_out, sp_we, busy, done, value_sel} !== '0) begin
      fails++;
      $display("FAIL reset: got req=%b addr=%h wr_en=%b sp_out=%h busy=%b done=%b, required all 0",
               mem_req, mem_addr, wr_en, sp_out, busy, done);
    end
    reset_n = 1;
  endtask

  task automatic test_empty;
    int d, r;
    run_seq(16'h0, 16'h0, 16'h1000, 16'h1234, 0, 0, d, r);
    tests++;
    if (r != 0) begin fails++; $display("FAIL empty_req: got %0d requests, required 0", r); end
  endtask

  task automatic test_push_int;
    int d, r;
    run_seq(16'h2600, 16'h0, 16'h0100, 16'h2000, 0, 0, d, r);
    tests++;
    if (r != 3) begin fails++; $display("FAIL push_int_req: got %0d requests, required 3", r); end
  endtask

  task automatic test_pop_reti;
    int d, r;
    rd_q = '{16'h1234, 16'h5678, 16'h0202};
    run_seq(16'h0, 16'h2600, 16'h00FA, 16'h2000, 0, 0, d, r);
  endtask

  task automatic test_pop_all;
    int d, r;
    run_seq(16'h0, 16'h00FF, 16'h0200, 16'h3000, 0, 0, d, r);
    tests++;
    if (r != 8) begin fails++; $display("FAIL pop_all_req: got %0d requests, required 8", r); end
  endtask

  task automatic test_wrap_wait;
    int d, r;
    run_seq(16'h0001, 16'h0, 16'h0000, 16'hFFFF, 3, 1, d, r);
    tests++;
    if (r != 4) begin fails++; $display("FAIL wrap_req: got %0d request cycles, required 4", r); end
  endtask

  task automatic test_back_to_back;
    int d, r;
    run_seq(16'h8011, 16'h0C10, 16'h8000, 16'h0040, 1, 0, d, r);
    run_seq(16'h0010, 16'h0, 16'h7FF0, 16'h0100, 0, 0, d, r);
    for (int k = 0; k < 4; k++)
      run_seq(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), k[0], d, r);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1; push_mask = 16'h0007; pop_mask = 0; sp_in = 16'h0100; ss_in = 0;
    @(negedge clk);
    start = 0; push_mask = 0; mem_ack = 0;
    tests++;
    if (mem_req !== 1) begin fails++; $display("FAIL mid_req: got req=%b, required 1", mem_req); end
    #2 reset_n = 0;
    #1;
    tests++;
    if (mem_req !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL async_reset: got req=%b busy=%b, required 0 0", mem_req, busy);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

`ifdef STACK_SEQ_ABORT_EN
  task automatic test_abort;
    int d, r;
    @(negedge clk);
    start = 1; push_mask = 16'h0007; pop_mask = 0; sp_in = 16'h0100; ss_in = 16'h2000;
    @(negedge clk);
    start = 0; push_mask = 0; mem_ack = 1;
    @(negedge clk);
    mem_ack = 0; abort = 1;
    tests++;
    if (mem_req !== 1) begin fails++; $display("FAIL abort_pre: got req=%b, required 1", mem_req); end
    @(negedge clk);
    abort = 0;
    tests++;
    if (mem_req !== 0 || done !== 0 || sp_we !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL abort: got req=%b done=%b sp_we=%b busy=%b, required 0 0 0 0", mem_req, done, sp_we, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 0 || mem_req !== 0) begin
      fails++;
      $display("FAIL abort_after: got done=%b req=%b, required 0 0", done, mem_req);
    end
    run_seq(16'h2600, 16'h0, 16'h0100, 16'h2000, 0, 0, d, r);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty();
    test_push_int();
    test_pop_reti();
    test_pop_all();
    test_wrap_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef STACK_SEQ_ABORT_EN
    test_abort();
`endif
    test_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
